shreg_seq_ctrl: RTL and testbench
=================================

SHREG_SEQ_CTRL -- requirements
Module: shreg_seq_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as the codebase does (Clk, MR_N).
REQ-002 Clk  in  1  rising-edge clock shared with the 4-bit universal shift register.
REQ-003 MR_N  in  1  asynchronous active-low reset, also wired to the shift register's MR_N.
REQ-004 cmd_valid  in  1  command offered.
REQ-005 cmd_ready  out  1  controller can accept a command.
REQ-006 cmd_op  in  3  operation code: 000 LOAD, 001 SHR, 010 SHL, 011 ROR, 100 ROL, 101 CLEAR; 110 and 111 are illegal.
REQ-007 cmd_cnt  in  3  step count for shift/rotate; 0 encodes 8.
REQ-008 cmd_data  in  4  parallel load value, bit order [0:3].
REQ-009 cmd_sin  in  1  serial fill bit for SHR/SHL.
REQ-010 abort  in  1  stop the current operation.
REQ-011 sr_q  in  4  shift-register Out[0:3] feedback.
REQ-012 sr_s  out  2  mode select: 00 hold, 01 shift right (Out[i]<=Out[i-1], Out[0]<=D[1]), 10 shift left (Out[i]<=Out[i+1], Out[3]<=D[0]), 11 parallel load.
REQ-013 sr_d  out  2  serial inputs D[1:0].
REQ-014 sr_p  out  4  parallel inputs In[0:3].
REQ-015 busy  out  1  operation in progress.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 err  out  1  status qualifier, valid only while done=1: 1 for an illegal op or an abort.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, EXEC, FIN, plus one reserved encoding that decodes to IDLE.
REQ-019 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge where cmd_valid=1 and cmd_ready=1.
REQ-020 On acceptance, the block SHALL latch op, cnt, data and sin, and move IDLE->EXEC (legal op) or IDLE->FIN with err=1 (illegal op).
REQ-021 The step counter SHALL load as follows: LOAD/CLEAR = 1; shift/rotate = cmd_cnt, with 0 loaded as 8 (4-bit counter).
REQ-022 In EXEC, sr_s SHALL be 11 for LOAD/CLEAR, 01 for SHR/ROR, and 10 for SHL/ROL, asserted for exactly the counted number of cycles.
REQ-023 The counter SHALL decrement on every EXEC cycle; the cycle with count=1 is the last, after which the FSM moves to FIN.
REQ-024 sr_p SHALL be the latched data for LOAD and 0000 for CLEAR; it SHALL be don't-care-driven-0 in all other cases.
REQ-025 SHR SHALL drive sr_d[1]=sin and SHL SHALL drive sr_d[0]=sin; the unused D bit SHALL be 0.
REQ-026 ROR SHALL drive sr_d[1]=sr_q[3] and ROL SHALL drive sr_d[0]=sr_q[0]; this is the only combinational input-to-output path.
REQ-027 In IDLE and FIN, sr_s SHALL be 00 and sr_d SHALL be 00.
REQ-028 FIN SHALL last one cycle with done=1, then return to IDLE.
REQ-029 busy SHALL be 1 in EXEC and FIN.
REQ-030 If abort=1 at an EXEC edge, sr_s SHALL be 00 from the next cycle, and the FSM SHALL enter FIN with err=1; the shifts already taken are kept.
REQ-031 abort SHALL be ignored in IDLE and FIN; if abort and the last step coincide, abort wins (err=1).
REQ-032 Latency SHALL be: accept at edge T, first mode cycle T+1, done in cycle T+1+N, with N = step count.
REQ-033 A new command SHALL be accepted no earlier than the cycle after FIN, giving a back-to-back throughput of one command per N+2 cycles.

Reset
REQ-034 While MR_N=0, the block SHALL be in state IDLE with cmd_ready=1, busy=0, done=0, err=0, sr_s=00, sr_d=00, sr_p=0000, and the counter and latches cleared.
REQ-035 Reset asserted mid-operation SHALL abandon the operation immediately, with no done pulse.
REQ-036 After reset release, the first command SHALL be acceptable at the first Clk edge.

Structure
REQ-037 The package shreg_pkg SHALL hold the op encodings, the sr_s mode constants (HOLD, SHR, SHL, LOAD) and the FSM state enum.
REQ-038 The step counter SHALL be the sub-module shreg_step_cnt, with load, decrement and last-step flag.
REQ-039 The bench SHALL instantiate the shift register together with shreg_seq_ctrl and check sr_q.

Verification
REQ-040 LOAD data=1011 -> sr_s=11 for 1 cycle; sr_q=1011; done 2 cycles after accept; err=0.
REQ-041 From sr_q=1011, ROR cnt=1 -> sr_q=1101; ROR cnt=0 (8 steps) -> sr_q=1011 after 8 shift cycles; done at T+9.
REQ-042 From 0000, SHL cnt=3 with sin=1 -> sr_q=0111; sr_s=10 for exactly 3 cycles.
REQ-043 SHR cnt=6 with abort at the 3rd EXEC edge -> 3 shifts applied, sr_s=00 afterwards, done=1 with err=1.
REQ-044 cmd_op=111 -> sr_s stays 00; done=1 with err=1 one cycle after accept; sr_q unchanged.
REQ-045 MR_N pulsed low during SHL cnt=5 -> all outputs at reset values, sr_q=0000, no done pulse; a LOAD issued afterwards completes normally.

Source files
------------

// File: rtl/shreg_pkg.sv
// Shared encodings for the shift-register sequencer: command opcodes,
// shift-register mode selects, FSM states and small opcode decode helpers.
package shreg_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b000;
  localparam logic [2:0] OP_SHR   = 3'b001;
  localparam logic [2:0] OP_SHL   = 3'b010;
  localparam logic [2:0] OP_ROR   = 3'b011;
  localparam logic [2:0] OP_ROL   = 3'b100;
  localparam logic [2:0] OP_CLEAR = 3'b101;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_FIN  = 2'b10,
    ST_RSVD = 2'b11
  } state_e;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= OP_CLEAR;
  endfunction

  // Number of mode cycles an opcode needs; a count field of 0 means 8.
  function automatic logic [3:0] op_steps(input logic [2:0] op, input logic [2:0] cnt);
    logic [3:0] steps;
    steps = 4'd0;
    case (op)
      OP_LOAD, OP_CLEAR:              steps = 4'd1;
      OP_SHR, OP_SHL, OP_ROR, OP_ROL: steps = (cnt == 3'd0) ? 4'd8 : {1'b0, cnt};
      default:                        steps = 4'd0;
    endcase
    return steps;
  endfunction

  function automatic logic [1:0] op_mode(input logic [2:0] op);
    logic [1:0] mode;
    mode = MODE_HOLD;
    case (op)
      OP_LOAD, OP_CLEAR: mode = MODE_LOAD;
      OP_SHR, OP_ROR:    mode = MODE_SHR;
      OP_SHL, OP_ROL:    mode = MODE_SHL;
      default:           mode = MODE_HOLD;
    endcase
    return mode;
  endfunction

endpackage

// File: rtl/shreg_step_cnt.sv
// Down-counter of remaining mode cycles; last flags the final cycle.
module shreg_step_cnt (
  input  logic       Clk,
  input  logic       MR_N,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] count,
  output logic       last
);

  always_ff @(posedge Clk or negedge MR_N) begin
    if (!MR_N) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && count != 4'd0) begin
      count <= count - 4'd1;
    end
  end

  assign last = (count == 4'd1);

endmodule

// File: rtl/shreg_univ4.sv
// 4-bit universal shift register; bus bit i carries Out[i] / In[i].
module shreg_univ4 (
  input  logic       Clk,
  input  logic       MR_N,
  input  logic [1:0] s,
  input  logic [1:0] d,
  input  logic [3:0] p,
  output logic [3:0] q
);

  always_ff @(posedge Clk or negedge MR_N) begin
    if (!MR_N) begin
      q <= 4'b0000;
    end else begin
      case (s)
        2'b01:   q <= {q[2:0], d[1]};
        2'b10:   q <= {d[0], q[3:1]};
        2'b11:   q <= p;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/shreg_seq_ctrl.sv
// Command sequencer driving a 4-bit universal shift register: accepts one
// load/shift/rotate/clear command at a time and steps the register's mode.
module shreg_seq_ctrl
  import shreg_pkg::*;
(
  input  logic       Clk,
  input  logic       MR_N,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [2:0] cmd_cnt,
  input  logic [3:0] cmd_data,
  input  logic       cmd_sin,
  input  logic       abort,
  input  logic [3:0] sr_q,
  output logic [1:0] sr_s,
  output logic [1:0] sr_d,
  output logic [3:0] sr_p,
  output logic       busy,
  output logic       done,
  output logic       err
);

  state_e     state_reg, state_next;
  logic [2:0] op_reg;
  logic [3:0] data_reg;
  logic       sin_reg;
  logic       err_reg;
  logic       accept;
  logic       last;
  logic [3:0] count;

  assign accept = cmd_valid && cmd_ready;

  shreg_step_cnt u_step_cnt (
    .Clk      (Clk),
    .MR_N     (MR_N),
    .load     (accept),
    .load_val (op_steps(cmd_op, cmd_cnt)),
    .dec      (state_reg == ST_EXEC),
    .count    (count),
    .last     (last)
  );

  always_ff @(posedge Clk or negedge MR_N) begin
    if (!MR_N) begin
      state_reg <= ST_IDLE;
      op_reg    <= 3'd0;
      data_reg  <= 4'd0;
      sin_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg   <= cmd_op;
        data_reg <= cmd_data;
        sin_reg  <= cmd_sin;
        err_reg  <= !op_legal(cmd_op);
      end else if (state_reg == ST_EXEC && abort) begin
        err_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    cmd_ready  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    err        = 1'b0;
    sr_s       = MODE_HOLD;
    sr_d       = 2'b00;
    sr_p       = 4'b0000;
    case (state_reg)
      ST_EXEC: begin
        busy = 1'b1;
        sr_s = op_mode(op_reg);
        case (op_reg)
          OP_LOAD: sr_p = data_reg;
          OP_SHR:  sr_d = {sin_reg, 1'b0};
          OP_SHL:  sr_d = {1'b0, sin_reg};
          // Rotates feed the register's own end bit back in the same cycle.
          OP_ROR:  sr_d = {sr_q[3], 1'b0};
          OP_ROL:  sr_d = {1'b0, sr_q[0]};
          default: sr_d = 2'b00;
        endcase
        if (abort || last) begin
          state_next = ST_FIN;
        end
      end
      ST_FIN: begin
        busy       = 1'b1;
        done       = 1'b1;
        err        = err_reg;
        state_next = ST_IDLE;
      end
      default: begin
        // The reserved encoding behaves exactly like IDLE.
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_next = op_legal(cmd_op) ? ST_EXEC : ST_FIN;
        end
      end
    endcase
  end

endmodule

// File: tb/tb_shreg_seq_ctrl.sv
// Bench for shreg_seq_ctrl driving a real universal shift register; directed
// and random commands checked against a list-level model of the register.
module tb_shreg_seq_ctrl;

  logic       Clk;
  logic       MR_N;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_cnt;
  logic [3:0] cmd_data;
  logic       cmd_sin;
  logic       abort;
  logic [3:0] sr_q;
  logic [1:0] sr_s;
  logic [1:0] sr_d;
  logic [3:0] sr_p;
  logic       busy;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;
  logic [3:0] q_model = 4'b0000;

  shreg_seq_ctrl dut (
    .Clk(Clk), .MR_N(MR_N), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data), .cmd_sin(cmd_sin),
    .abort(abort), .sr_q(sr_q), .sr_s(sr_s), .sr_d(sr_d), .sr_p(sr_p),
    .busy(busy), .done(done), .err(err)
  );

  shreg_univ4 u_sr (
    .Clk(Clk), .MR_N(MR_N), .s(sr_s), .d(sr_d), .p(sr_p), .q(sr_q)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // A literal written in Out[0:3] reading order -> bus with bit i = Out[i].
  function automatic logic [3:0] o2b(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  function automatic int steps_of(input logic [2:0] op, input logic [2:0] cnt);
    if (op == 3'd0 || op == 3'd5) return 1;
    if (op <= 3'd4) return (cnt == 3'd0) ? 8 : int'(cnt);
    return 0;
  endfunction

  function automatic logic [1:0] mode_of(input logic [2:0] op);
    case (op)
      3'd0, 3'd5: return 2'b11;
      3'd1, 3'd3: return 2'b01;
      3'd2, 3'd4: return 2'b10;
      default:    return 2'b00;
    endcase
  endfunction

  // Register contents after k steps of op, viewed as the list Out[0..3].
  function automatic logic [3:0] model(input logic [2:0] op, input logic [3:0] q,
                                       input logic [3:0] data, input logic sin, input int k);
    logic [3:0] r;
    int src;
    r = q;
    if (k == 0) return q;
    for (int i = 0; i < 4; i++) begin
      case (op)
        3'd0: r[i] = data[i];
        3'd5: r[i] = 1'b0;
        3'd1: begin src = i - k; r[i] = (src >= 0) ? q[src] : sin; end
        3'd2: begin src = i + k; r[i] = (src <= 3) ? q[src] : sin; end
        3'd3: r[i] = q[((i - k) % 4 + 4) % 4];
        3'd4: r[i] = q[(i + k) % 4];
        default: r[i] = q[i];
      endcase
    end
    return r;
  endfunction

  task automatic run_cmd(input logic [2:0] op, input logic [2:0] cnt, input logic [3:0] data,
                         input logic sin, input int abort_at);
    int n, k_exp, mode_cycles, done_at;
    logic legal, exp_err;
    logic [3:0] q_before, cur;
    n = steps_of(op, cnt);
    legal = (op <= 3'd5);
    exp_err = !legal || (abort_at > 0 && abort_at <= n);
    k_exp = !legal ? 0 : ((abort_at > 0 && abort_at <= n) ? abort_at : n);
    mode_cycles = 0;
    done_at = 0;
    @(negedge Clk);
    chk("ready_idle", {7'd0, cmd_ready}, 8'd1);
    q_before = q_model;
    cmd_valid = 1'b1; cmd_op = op; cmd_cnt = cnt; cmd_data = data; cmd_sin = sin;
    @(posedge Clk);
    #1 cmd_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge Clk);
      if (sr_s != 2'b00) begin
        cur = model(op, q_before, data, sin, mode_cycles);
        chk("sr_s_mode", {6'd0, sr_s}, {6'd0, mode_of(op)});
        chk("sr_q_step", {4'd0, sr_q}, {4'd0, cur});
        case (op)
          3'd1: chk("sr_d", {6'd0, sr_d}, {6'd0, sin, 1'b0});
          3'd2: chk("sr_d", {6'd0, sr_d}, {6'd0, 1'b0, sin});
          3'd3: chk("sr_d", {6'd0, sr_d}, {6'd0, cur[3], 1'b0});
          3'd4: chk("sr_d", {6'd0, sr_d}, {6'd0, 1'b0, cur[0]});
          default: chk("sr_d", {6'd0, sr_d}, 8'd0);
        endcase
        chk("sr_p", {4'd0, sr_p}, (op == 3'd0) ? {4'd0, data} : 8'd0);
        mode_cycles++;
      end else if (!done) begin
        chk("sr_d_hold", {6'd0, sr_d}, 8'd0);
      end
      abort = (legal && c == abort_at && c <= n);
      if (done) begin
        done_at = c;
        chk("err", {7'd0, err}, {7'd0, exp_err});
        chk("busy_fin", {7'd0, busy}, 8'd1);
        chk("ready_fin", {7'd0, cmd_ready}, 8'd0);
        chk("sr_s_fin", {6'd0, sr_s}, 8'd0);
        break;
      end
    end
    abort = 1'b0;
    if (done_at == 0) chk("done_timeout", 8'd0, 8'd1);
    else chk("done_at", 8'(done_at), 8'(k_exp + 1));
    chk("mode_cycles", 8'(mode_cycles), 8'(k_exp));
    q_model = model(op, q_before, data, sin, k_exp);
    chk("sr_q_final", {4'd0, sr_q}, {4'd0, q_model});
    @(negedge Clk);
    chk("ready_after", {7'd0, cmd_ready}, 8'd1);
    chk("done_after", {7'd0, done}, 8'd0);
    $display("cmd op=%0d cnt=%0d data=%b sin=%0d abort_at=%0d done_at=%0d err_exp=%0d q=%b",
             op, cnt, data, sin, abort_at, done_at, exp_err, sr_q);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {7'd0, cmd_ready}, 8'd1);
    chk({tag, "_busy"}, {7'd0, busy}, 8'd0);
    chk({tag, "_done"}, {7'd0, done}, 8'd0);
    chk({tag, "_err"}, {7'd0, err}, 8'd0);
    chk({tag, "_sr_s"}, {6'd0, sr_s}, 8'd0);
    chk({tag, "_sr_d"}, {6'd0, sr_d}, 8'd0);
    chk({tag, "_sr_p"}, {4'd0, sr_p}, 8'd0);
    chk({tag, "_sr_q"}, {4'd0, sr_q}, 8'd0);
  endtask

  initial begin
    int n, ab;
    logic [2:0] op;
    logic [2:0] cnt;
    logic saw_done;
    MR_N = 1'b0; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_cnt = 3'd0;
    cmd_data = 4'd0; cmd_sin = 1'b0; abort = 1'b0;
    repeat (2) @(negedge Clk);
    chk_reset_outputs("reset");
    MR_N = 1'b1;

    run_cmd(3'd0, 3'd0, o2b(4'b1011), 1'b0, 0);
    chk("load_1011", {4'd0, sr_q}, {4'd0, o2b(4'b1011)});
    run_cmd(3'd3, 3'd1, 4'd0, 1'b0, 0);
    chk("ror1_1101", {4'd0, sr_q}, {4'd0, o2b(4'b1101)});
    run_cmd(3'd0, 3'd0, o2b(4'b1011), 1'b0, 0);
    run_cmd(3'd3, 3'd0, 4'd0, 1'b0, 0);
    chk("ror8_1011", {4'd0, sr_q}, {4'd0, o2b(4'b1011)});
    run_cmd(3'd5, 3'd0, 4'd0, 1'b0, 0);
    run_cmd(3'd2, 3'd3, 4'd0, 1'b1, 0);
    chk("shl3_0111", {4'd0, sr_q}, {4'd0, o2b(4'b0111)});
    run_cmd(3'd1, 3'd6, 4'd0, 1'b1, 3);
    run_cmd(3'd7, 3'd2, 4'hF, 1'b1, 0);
    run_cmd(3'd4, 3'd2, 4'd0, 1'b0, 2);

    // abort while idle must not start anything
    @(negedge Clk);
    abort = 1'b1;
    @(negedge Clk);
    abort = 1'b0;
    chk("abort_idle_busy", {7'd0, busy}, 8'd0);
    chk("abort_idle_q", {4'd0, sr_q}, {4'd0, q_model});

    // reset in the middle of SHL cnt=5
    @(negedge Clk);
    cmd_valid = 1'b1; cmd_op = 3'd2; cmd_cnt = 3'd5; cmd_sin = 1'b1;
    @(posedge Clk);
    #1 cmd_valid = 1'b0;
    repeat (2) @(negedge Clk);
    MR_N = 1'b0;
    #1 chk_reset_outputs("midrst");
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      saw_done = saw_done | done;
    end
    chk("midrst_no_done", {7'd0, saw_done}, 8'd0);
    @(posedge Clk);
    #2 MR_N = 1'b1;
    q_model = 4'b0000;
    run_cmd(3'd0, 3'd0, o2b(4'b0110), 1'b0, 0);
    chk("load_after_rst", {4'd0, sr_q}, {4'd0, o2b(4'b0110)});

    for (int t = 0; t < 24; t++) begin
      op  = 3'($urandom_range(0, 7));
      cnt = 3'($urandom_range(0, 7));
      n   = steps_of(op, cnt);
      ab  = (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, n)) : 0;
      run_cmd(op, cnt, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
